// File: rtl/conv_pkg.sv
// Shared types and width helpers for the multi-channel convolution controller.
package conv_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PUSH,
    WAIT_RES,
    DRAIN,
    DONE
  } conv_state_e;

  // Number of valid output rows (and output columns) of a KxK valid convolution.
  function automatic int unsigned out_rows(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

  // $clog2 that never yields a zero-width field.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_res_collector.sv
// Result collector: sticky per-channel capture of engine result columns and
// channel-serialising output register with hold under backpressure.
// Optional macro CONV_OUT_RELU_EN zeroes negative FP16 lanes on m_data.
// Ports: cap_en/eng_valid/eng_res capture side; drain_en/col_idx drain control;
//        m_* ready/valid stream; all_flags_c, drain_done_c status to the FSM.
module conv_res_collector
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned OUT_ROWS   = 24,
  localparam int unsigned ROW_W     = OUT_ROWS * DATA_WIDTH,
  localparam int unsigned CH_W      = width_of(NUM_CH),
  localparam int unsigned COLIDX_W  = width_of(OUT_ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_en,
  input  logic [NUM_CH-1:0]       eng_valid,
  input  logic [NUM_CH*ROW_W-1:0] eng_res,
  input  logic                    drain_en,
  input  logic [COLIDX_W-1:0]     col_idx,
  input  logic                    m_ready,
  output logic [ROW_W-1:0]        m_data,
  output logic [CH_W-1:0]         m_chan,
  output logic [COLIDX_W-1:0]     m_col,
  output logic                    m_valid,
  output logic                    m_last,
  output logic                    all_flags_c,
  output logic                    drain_done_c
);

  logic [NUM_CH-1:0] flags;
  logic [ROW_W-1:0]  cap [NUM_CH];
  logic [ROW_W-1:0]  beat_q;
  logic              first_c, hs_c, last_ch_c, load_c;
  logic [CH_W-1:0]   next_ch_c;

  // First beat loads on DRAIN entry; later beats load on each accepted beat.
  assign first_c      = drain_en && !m_valid;
  assign hs_c         = m_valid && m_ready;
  assign last_ch_c    = (m_chan == CH_W'(NUM_CH - 1));
  assign load_c       = first_c || (hs_c && !last_ch_c);
  assign next_ch_c    = first_c ? '0 : m_chan + CH_W'(1);
  assign all_flags_c  = &flags;
  assign drain_done_c = hs_c && last_ch_c;

  // Capture registers and output beat register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags   <= '0;
      for (int i = 0; i < NUM_CH; i++) cap[i] <= '0;
      beat_q  <= '0;
      m_chan  <= '0;
      m_col   <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_en && eng_valid[i]) begin
          flags[i] <= 1'b1;
          cap[i]   <= eng_res[i*ROW_W +: ROW_W];
        end
      end
      if (load_c) begin
        m_valid <= 1'b1;
        beat_q  <= cap[next_ch_c];
        m_chan  <= next_ch_c;
        m_col   <= col_idx;
        m_last  <= (next_ch_c == CH_W'(NUM_CH - 1)) && (col_idx == COLIDX_W'(OUT_ROWS - 1));
      end else if (hs_c) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        flags   <= '0;
      end
    end
  end

`ifdef CONV_OUT_RELU_EN
  // ReLU on the registered beat: any lane with the sign bit set (incl. -0) reads as zero.
  always_comb begin
    m_data = beat_q;
    for (int i = 0; i < OUT_ROWS; i++) begin
      if (beat_q[i*DATA_WIDTH + DATA_WIDTH - 1]) m_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end
`else
  assign m_data = beat_q;
`endif

endmodule

// File: rtl/conv_multi_ch_stream.sv
// Multi-channel convolution controller: fetches image columns from BRAM,
// broadcasts them to NUM_CH engines, collects their result columns and
// streams them out channel by channel with ready/valid backpressure.
// Optional macro CONV_OUT_RELU_EN (in conv_res_collector) applies FP16 ReLU to m_data.
// Ports: start/base_addr launch; bram_addr/bram_rdata BRAM read port;
//        col_data/col_valid engine broadcast; eng_res/eng_valid engine results;
//        m_data/m_chan/m_col/m_valid/m_ready/m_last output stream; busy/done status.
module conv_multi_ch_stream
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned KERNEL_SIZE  = 5,
  parameter int unsigned IMAGE_SIZE   = 28,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned BRAM_WIDTH   = 512,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned OUT_ROWS    = out_rows(IMAGE_SIZE, KERNEL_SIZE),
  localparam int unsigned COL_W       = IMAGE_SIZE * DATA_WIDTH,
  localparam int unsigned ROW_W       = OUT_ROWS * DATA_WIDTH,
  localparam int unsigned CH_W        = width_of(NUM_CH),
  localparam int unsigned COLIDX_W    = width_of(OUT_ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  input  logic [BRAM_WIDTH-1:0]   bram_rdata,
  output logic [COL_W-1:0]        col_data,
  output logic                    col_valid,
  input  logic [NUM_CH*ROW_W-1:0] eng_res,
  input  logic [NUM_CH-1:0]       eng_valid,
  output logic [ROW_W-1:0]        m_data,
  output logic [CH_W-1:0]         m_chan,
  output logic [COLIDX_W-1:0]     m_col,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CW = width_of(IMAGE_SIZE);
  localparam int unsigned LW = 2;

  conv_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, bram_addr_d;
  logic [CW-1:0]         c_q, c_d, c_inc;
  logic [LW-1:0]         lat_q, lat_d;
  logic [COL_W-1:0]      col_data_d;
  logic                  col_valid_d, busy_d, done_d;
  logic                  all_flags_c, drain_done_c;
  logic [COLIDX_W-1:0]   col_idx;

  assign c_inc   = c_q + CW'(1);
  assign col_idx = COLIDX_W'(c_q - CW'(KERNEL_SIZE - 1));

  // Rows above the image in the BRAM word are never used.
  if (BRAM_WIDTH > COL_W) begin : g_rdata_hi
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bram_rdata[BRAM_WIDTH-1:COL_W];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    c_d         = c_q;
    lat_d       = lat_q;
    bram_addr_d = bram_addr;
    col_data_d  = col_data;
    col_valid_d = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = base_addr;
          c_d         = '0;
          lat_d       = '0;
          bram_addr_d = base_addr;
          busy_d      = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // Address is held from FETCH entry; data is valid READ_LATENCY cycles later.
        if (lat_q == LW'(READ_LATENCY)) begin
          col_data_d  = bram_rdata[COL_W-1:0];
          col_valid_d = 1'b1;
          state_d     = PUSH;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      PUSH: begin
        if (c_q < CW'(KERNEL_SIZE - 1)) begin
          c_d         = c_inc;
          lat_d       = '0;
          bram_addr_d = base_q + ADDR_WIDTH'(c_inc);
          state_d     = FETCH;
        end else begin
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (all_flags_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done_c) begin
          if (c_q == CW'(IMAGE_SIZE - 1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            c_d         = c_inc;
            lat_d       = '0;
            bram_addr_d = base_q + ADDR_WIDTH'(c_inc);
            state_d     = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      c_q       <= '0;
      lat_q     <= '0;
      bram_addr <= '0;
      col_data  <= '0;
      col_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      c_q       <= c_d;
      lat_q     <= lat_d;
      bram_addr <= bram_addr_d;
      col_data  <= col_data_d;
      col_valid <= col_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  conv_res_collector #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH),
    .OUT_ROWS   (OUT_ROWS)
  ) u_collector (
    .clk          (clk),
    .rst          (rst),
    .cap_en       (state_q == WAIT_RES),
    .eng_valid    (eng_valid),
    .eng_res      (eng_res),
    .drain_en     (state_q == DRAIN),
    .col_idx      (col_idx),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_chan       (m_chan),
    .m_col        (m_col),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .all_flags_c  (all_flags_c),
    .drain_done_c (drain_done_c)
  );

endmodule

// File: tb/tb_conv_multi_ch_stream.sv
// Scoreboard bench for conv_multi_ch_stream: BRAM and engine models drive the
// DUT, expected beats are queued when engine replies are scheduled, and a
// monitor pops and compares on every accepted output beat.
module tb_conv_multi_ch_stream;
  import conv_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned IMG   = 28;
  localparam int unsigned K     = 5;
  localparam int unsigned NCH   = 4;
  localparam int unsigned AW    = 12;
  localparam int unsigned BW    = 512;
  localparam int unsigned OR    = IMG - K + 1;
  localparam int unsigned ROW_W = OR * DW;
  localparam int unsigned COL_W = IMG * DW;

  logic             clk, rst, start, col_valid, m_valid, m_ready, m_last, busy, done;
  logic [AW-1:0]    base_addr, bram_addr;
  logic [BW-1:0]    bram_rdata;
  logic [COL_W-1:0] col_data;
  logic [NCH*ROW_W-1:0] eng_res;
  logic [NCH-1:0]   eng_valid;
  logic [ROW_W-1:0] m_data;
  logic [1:0]       m_chan;
  logic [4:0]       m_col;

  typedef struct packed {
    logic [ROW_W-1:0] data;
    logic [1:0]       chan;
    logic [4:0]       col;
    logic             last;
  } beat_t;

  beat_t     exp_q[$];
  int        checks = 0, errors = 0;
  int        img_id, ready_mode, cyc;
  int        dly[NCH];
  logic [AW-1:0] cur_base;
  int        eng_cols, mon_cols, beats, dones, lasts;
  bit        exp_busy;
  bit        ok;

  conv_multi_ch_stream #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_SIZE(IMG), .NUM_CH(NCH),
    .BRAM_WIDTH(BW), .ADDR_WIDTH(AW), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .bram_addr(bram_addr), .bram_rdata(bram_rdata),
    .col_data(col_data), .col_valid(col_valid),
    .eng_res(eng_res), .eng_valid(eng_valid),
    .m_data(m_data), .m_chan(m_chan), .m_col(m_col), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [BW-1:0] bram_word(input logic [AW-1:0] a);
    logic [BW-1:0] w;
    w = '1;
    for (int r = 0; r < IMG; r++) w[r*DW +: DW] = 16'(int'(a) * 32 + r);
    return w;
  endfunction

  function automatic fp16_t eng_lane(input int im, input int col, input int ch, input int r);
    if (r == 0) return 16'hBC00;
    if (r == 1) return 16'h3C00;
    return 16'(im * 4096 + col * 128 + ch * 32 + r);
  endfunction

  function automatic fp16_t exp_lane(input int im, input int col, input int ch, input int r);
    fp16_t v;
    v = eng_lane(im, col, ch, r);
`ifdef CONV_OUT_RELU_EN
    if (v[15]) v = '0;
`endif
    return v;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // BRAM (latency 1), engine models, m_ready pattern and expected-beat producer.
  initial begin
    int cnt[NCH];
    int pcol[NCH];
    logic [AW-1:0] prev_addr;
    beat_t b;
    prev_addr = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      m_ready    = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      bram_rdata = bram_word(prev_addr);
      prev_addr  = bram_addr;
      eng_valid  = '0;
      if (!rst) begin
        for (int ch = 0; ch < NCH; ch++) cnt[ch] = 0;
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (cnt[ch] > 0) begin
            cnt[ch]--;
            if (cnt[ch] == 0) begin
              eng_valid[ch] = 1'b1;
              for (int r = 0; r < OR; r++)
                eng_res[(ch*OR + r)*DW +: DW] = eng_lane(img_id, pcol[ch], ch, r);
            end
          end
        end
        if (col_valid) begin
          if (eng_cols >= K - 1) begin
            for (int ch = 0; ch < NCH; ch++) begin
              cnt[ch]  = dly[ch];
              pcol[ch] = eng_cols;
              b.data   = '0;
              for (int r = 0; r < OR; r++) b.data[r*DW +: DW] = exp_lane(img_id, eng_cols, ch, r);
              b.chan = 2'(ch);
              b.col  = 5'(eng_cols - (K - 1));
              b.last = (ch == NCH - 1) && (eng_cols == IMG - 1);
              exp_q.push_back(b);
            end
          end
          eng_cols++;
        end
      end
    end
  end

  // Monitor: column broadcast, busy, hold under stall, beat scoreboard.
  initial begin
    logic          prev_stall, prev_valid, p_last;
    logic [ROW_W-1:0] p_data;
    logic [1:0]    p_chan;
    logic [4:0]    p_col;
    logic [AW-1:0] p_addr, ea;
    logic [BW-1:0] w;
    logic [COL_W-1:0] ecol;
    beat_t e;
    prev_stall = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (col_valid) begin
          ea   = AW'(cur_base + AW'(mon_cols));
          w    = bram_word(ea);
          ecol = w[COL_W-1:0];
          chk("col_data", col_data, ecol);
          chk("bram_addr", bram_addr, ea);
          mon_cols++;
        end
        if (done) dones++;
        if (exp_busy) begin
          if (done) begin
            chk("busy_at_done", busy, 0);
            exp_busy = 1'b0;
          end else begin
            chk("busy", busy, 1);
          end
        end
        if (prev_stall) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_beat", {m_data, m_chan, m_col, m_last}, {p_data, p_chan, p_col, p_last});
        end
        if (prev_valid && m_valid) chk("addr_during_drain", bram_addr, p_addr);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat chan=%0d col=%0d required=no beat", m_chan, m_col);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e.data);
            chk("beat_tag", {m_chan, m_col, m_last}, {e.chan, e.col, e.last});
          end
          beats++;
          if (m_last) lasts++;
        end
        prev_stall = m_valid && !m_ready;
        prev_valid = m_valid;
        p_data = m_data; p_chan = m_chan; p_col = m_col; p_last = m_last; p_addr = bram_addr;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {bram_addr, col_valid, m_valid, m_chan, m_col, m_last, busy, done}, 0);
    chk({tag, "_col_data"}, col_data, 0);
    chk({tag, "_m_data"}, m_data, 0);
  endtask

  task automatic start_image(input int im, input logic [AW-1:0] base, input int mode,
                             input int d0, input int d1, input int d2, input int d3);
    img_id = im; cur_base = base; ready_mode = mode;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    eng_cols = 0; mon_cols = 0; beats = 0; dones = 0; lasts = 0;
    @(posedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = ~base;
    exp_busy  = 1'b1;
  endtask

  task automatic wait_done(input bit mid_start, input bit done_start);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (mid_start) start = (i == 150);
      if (done) begin
        if (done_start) start = 1'b1;
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic end_image(input int exp_dones);
    repeat (5) @(posedge clk);
    #1;
    chk("col_valid_pulses", mon_cols, IMG);
    chk("beats", beats, OR * NCH);
    chk("done_pulses", dones, exp_dones);
    chk("last_beats", lasts, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; m_ready = 1'b1;
    eng_valid = '0; eng_res = '0; bram_rdata = '0;
    img_id = 0; ready_mode = 0; cyc = 0; exp_busy = 1'b0; cur_base = '0;
    eng_cols = 0; mon_cols = 0; beats = 0; dones = 0; lasts = 0;
    for (int i = 0; i < NCH; i++) dly[i] = 2;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Nominal image: engines answer together 2 cycles after each column.
    start_image(1, 12'h100, 0, 2, 2, 2, 2);
    wait_done(1'b0, 1'b0);
    end_image(1);

    // Out-of-order replies, 1-in-3 ready, address wrap, stray starts.
    start_image(2, 12'hFF0, 1, 4, 3, 2, 1);
    wait_done(1'b1, 1'b1);
    end_image(1);

    // Abort during the drain of column 10 (output column 6).
    start_image(3, 12'h100, 0, 2, 2, 2, 2);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_valid && m_col == 5'd6) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reached_col10_drain", ok, 1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_abort", dones, 0);
    chk("idle_after_abort", busy, 0);

    // Fresh full image after the abort.
    start_image(4, 12'h100, 0, 2, 2, 2, 2);
    wait_done(1'b0, 1'b0);
    end_image(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
